// File: rtl/cam_capture.sv
// Camera-to-framebuffer capture: assembles RGB565 pixels from a byte stream and writes them linearly.
// Optional CAM_CAPTURE_FRAME_SKIP_EN: write only every other frame (first frame after reset skipped).
module cam_capture #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic        PCLK,
    input  logic        RST,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  din,
    output logic [16:0] pixel_address,
    output logic [15:0] pixel_data,
    output logic        we,
    output logic        frame_done,
    output logic        frame_ok
);

    localparam logic [16:0] FRAME_SZ = 17'(IMG_W * IMG_H);

    typedef enum logic [1:0] {WAIT_VS, VS, HI, LO} state_t;

    state_t      state_q;
    logic        vsync_r, href_r;
    logic [7:0]  din_r;
    logic [7:0]  hi_q;
    logic [16:0] wr_addr_q;
    logic        ovf_q;
    logic        cap_en;

`ifdef CAM_CAPTURE_FRAME_SKIP_EN
    logic toggle_q, cap_en_q;
    assign cap_en = cap_en_q;
`else
    assign cap_en = 1'b1;
`endif

    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            state_q       <= WAIT_VS;
            vsync_r       <= 1'b0;
            href_r        <= 1'b0;
            din_r         <= 8'd0;
            hi_q          <= 8'd0;
            wr_addr_q     <= 17'd0;
            ovf_q         <= 1'b0;
            pixel_address <= 17'd0;
            pixel_data    <= 16'd0;
            we            <= 1'b0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
`ifdef CAM_CAPTURE_FRAME_SKIP_EN
            toggle_q      <= 1'b0;
            cap_en_q      <= 1'b0;
`endif
        end else begin
            vsync_r    <= vsync;
            href_r     <= href;
            din_r      <= din;
            we         <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            case (state_q)
                WAIT_VS: if (vsync_r) state_q <= VS;
                VS: begin
                    if (!vsync_r) begin
                        wr_addr_q <= 17'd0;
                        ovf_q     <= 1'b0;
                        state_q   <= HI;
`ifdef CAM_CAPTURE_FRAME_SKIP_EN
                        // The frame starting now uses the pre-toggle value, so frame 1 is skipped
                        cap_en_q  <= toggle_q;
                        toggle_q  <= ~toggle_q;
`endif
                    end
                end
                HI: begin
                    if (vsync_r) begin
                        frame_done <= 1'b1;
                        frame_ok   <= (wr_addr_q == FRAME_SZ) && !ovf_q;
                        state_q    <= VS;
                    end else if (href_r) begin
                        hi_q    <= din_r;
                        state_q <= LO;
                    end
                end
                LO: begin
                    // End of frame wins over a pixel completing in the same cycle
                    if (vsync_r) begin
                        frame_done <= 1'b1;
                        frame_ok   <= (wr_addr_q == FRAME_SZ) && !ovf_q;
                        state_q    <= VS;
                    end else begin
                        state_q <= HI;
                        if (href_r) begin
                            if (wr_addr_q == FRAME_SZ) begin
                                ovf_q <= 1'b1;
                            end else begin
                                wr_addr_q <= wr_addr_q + 17'd1;
                                if (cap_en) begin
                                    we            <= 1'b1;
                                    pixel_address <= wr_addr_q;
                                    pixel_data    <= {hi_q, din_r};
                                end
                            end
                        end
                    end
                end
                default: state_q <= WAIT_VS;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Randomized scoreboard bench for cam_capture on a reduced frame (8x6 pixels).
module tb_cam_capture;
    localparam int W = 8, H = 6, FRAME = W * H;

    logic        PCLK = 1'b0, RST = 1'b0, vsync = 1'b0, href = 1'b0;
    logic [7:0]  din = 8'd0;
    logic [16:0] pixel_address;
    logic [15:0] pixel_data;
    logic        we, frame_done, frame_ok;

    cam_capture #(.IMG_W(W), .IMG_H(H)) dut (
        .PCLK(PCLK), .RST(RST), .vsync(vsync), .href(href), .din(din),
        .pixel_address(pixel_address), .pixel_data(pixel_data), .we(we),
        .frame_done(frame_done), .frame_ok(frame_ok)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed { logic [16:0] addr; logic [15:0] data; } wr_t;
    wr_t wq[$];
    bit  fq[$];
    int  n_checks = 0, n_fail = 0, cyc = 0;

    // Reference model state: one frame is just a pixel count, an overflow flag and a write-enable
    int  m_addr = 0, m_fc = 0;
    bit  m_ovf = 0, m_active = 0, m_cap = 1;
    logic [16:0] last_addr = 17'd0;
    logic [15:0] last_data = 16'd0;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge PCLK) begin
        wr_t e;
        #1;
        if (RST) begin
            last_addr = 17'd0;
            last_data = 16'd0;
        end else begin
            if (we) begin
                if (wq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_we: addr %0d data %0h, none expected", pixel_address, pixel_data);
                end else begin
                    e = wq.pop_front();
                    check("wr_addr", 32'(pixel_address), 32'(e.addr));
                    check("wr_data", 32'(pixel_data), 32'(e.data));
                    last_addr = e.addr;
                    last_data = e.data;
                end
            end else begin
                check("hold_addr", 32'(pixel_address), 32'(last_addr));
                check("hold_data", 32'(pixel_data), 32'(last_data));
            end
            if (frame_done) begin
                if (fq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_frame_done: frame_ok %0b, none expected", frame_ok);
                end else begin
                    check("frame_ok", 32'(frame_ok), 32'(fq.pop_front()));
                end
            end
        end
    end

    task automatic drive(bit h, logic [7:0] d, bit v);
        @(negedge PCLK);
        href = h; din = d; vsync = v;
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 8'd0, 1'b0);
    endtask

    task automatic model_pixel(logic [7:0] hi, logic [7:0] lo);
        if (m_addr == FRAME) m_ovf = 1;
        else begin
            if (m_cap) wq.push_back({17'(m_addr), hi, lo});
            m_addr++;
        end
    endtask

    task automatic model_end();
        if (m_active) fq.push_back(m_addr == FRAME && !m_ovf);
        m_active = 0;
    endtask

    task automatic model_start();
        m_addr = 0; m_ovf = 0; m_active = 1;
`ifdef CAM_CAPTURE_FRAME_SKIP_EN
        m_cap = (m_fc % 2) == 1;
`else
        m_cap = 1;
`endif
        m_fc++;
    endtask

    task automatic vsync_pulse();
        model_end();
        repeat (3) drive(1'b0, 8'd0, 1'b1);
        model_start();
        idle(3);
    endtask

    task automatic send_line(int nbytes, bit track);
        logic [7:0] b, prev;
        prev = 8'd0;
        for (int i = 0; i < nbytes; i++) begin
            b = 8'($urandom);
            drive(1'b1, b, 1'b0);
            if (track && (i % 2 == 1)) model_pixel(prev, b);
            prev = b;
        end
        idle(1 + $urandom_range(0, 3));
    endtask

    // Last low byte arrives together with vsync: that pixel is lost, the frame ends
    task automatic line_with_vsync(int npairs);
        logic [7:0] b, prev;
        prev = 8'd0;
        for (int i = 0; i < 2 * npairs; i++) begin
            b = 8'($urandom);
            drive(1'b1, b, (i == 2 * npairs - 1));
            if ((i % 2 == 1) && (i != 2 * npairs - 1)) model_pixel(prev, b);
            prev = b;
        end
        model_end();
        repeat (2) drive(1'b0, 8'd0, 1'b1);
        model_start();
        idle(3);
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        RST = 1'b1; href = 1'b0; vsync = 1'b0; din = 8'd0;
        #1;
        check("rst_addr", 32'(pixel_address), 32'd0);
        check("rst_data", 32'(pixel_data), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_ok", 32'(frame_ok), 32'd0);
        repeat (2) @(negedge PCLK);
        RST = 1'b0;
        m_active = 0; m_fc = 0; m_addr = 0; m_ovf = 0;
    endtask

    // Bytes are launched after edge N and sampled at N+1; the write must be visible after edge N+3
    task automatic latency_pixel();
        int exp_cyc, seen;
        drive(1'b1, 8'hF8, 1'b0);
        exp_cyc = cyc + 3;
        drive(1'b1, 8'h1F, 1'b0);
        model_pixel(8'hF8, 8'h1F);
        drive(1'b0, 8'd0, 1'b0);
        seen = -1;
        for (int k = 0; k < 8 && seen < 0; k++) begin
            @(posedge PCLK); #1;
            if (we) seen = cyc;
        end
        check("latency_cycle", 32'(seen), 32'(exp_cyc));
        check("latency_data", 32'(pixel_data), 32'h0000F81F);
    endtask

    initial begin
        #1 RST = 1'b1;
        #2;
        check("init_addr", 32'(pixel_address), 32'd0);
        check("init_we", 32'(we), 32'd0);
        check("init_done", 32'(frame_done), 32'd0);
        repeat (2) @(negedge PCLK);
        RST = 1'b0;
        idle(2);
        // Activity before any vsync must be ignored
        send_line(16, 1'b0);

        vsync_pulse();                                  // frame 1: full
        for (int l = 0; l < H; l++) send_line(2 * W, 1'b1);
        vsync_pulse();                                  // frame 2: latency pixel, then fill
        latency_pixel();
        send_line(2 * W - 2, 1'b1);
        for (int l = 1; l < H; l++) send_line(2 * W, 1'b1);
        vsync_pulse();                                  // frame 3: odd first line
        send_line(2 * W + 1, 1'b1);
        for (int l = 1; l < H; l++) send_line(2 * W, 1'b1);
        vsync_pulse();                                  // frame 4: overflow
        for (int l = 0; l < H + 1; l++) send_line(2 * W, 1'b1);
        vsync_pulse();                                  // frame 5: short
        for (int l = 0; l < 3; l++) send_line(2 * W, 1'b1);
        vsync_pulse();                                  // frame 6: ends on a completing pixel
        for (int l = 0; l < 2; l++) send_line(2 * W, 1'b1);
        line_with_vsync(4);
        for (int l = 0; l < 3; l++) send_line(2 * W, 1'b1); // frame 7: aborted by reset
        idle(4);
        do_reset();
        for (int l = 0; l < 2; l++) send_line(2 * W, 1'b0);
        vsync_pulse();                                  // first frame after reset
        for (int l = 0; l < H; l++) send_line(2 * W, 1'b1);
        vsync_pulse();                                  // second frame after reset
        for (int l = 0; l < H; l++) send_line(2 * W, 1'b1);
        model_end();
        repeat (3) drive(1'b0, 8'd0, 1'b1);
        idle(10);

        check("writes_left", 32'(wq.size()), 32'd0);
        check("frames_left", 32'(fq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 SHALL have parameter IMG_W, default 320, pixels per captured line.
REQ-002 SHALL have parameter IMG_H, default 240, captured lines per frame; frame size IMG_W*IMG_H = 76800 words.
REQ-003 SHALL have port PCLK  input  1  camera pixel clock; the only clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port vsync  input  1  camera frame sync, active high.
REQ-006 SHALL have port href  input  1  camera line-valid, high while bytes are valid.
REQ-007 SHALL have port din  input  8  camera data byte, RGB565, high byte first.
REQ-008 SHALL have port pixel_address  output  17  framebuffer write address, 0..76799.
REQ-009 SHALL have port pixel_data  output  16  assembled RGB565 pixel {high byte, low byte}.
REQ-010 SHALL have port we  output  1  framebuffer write strobe, one PCLK cycle per pixel.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at end of each captured frame.
REQ-012 SHALL have port frame_ok  output  1  valid with frame_done; 1 iff exactly 76800 pixels were written.

Function
REQ-013 SHALL register vsync, href, din once (vsync_r, href_r, din_r); the FSM uses only the registered copies.
REQ-014 SHALL implement states WAIT_VS, VS, HI, LO.
REQ-015 WAIT_VS: SHALL go to VS when vsync_r=1, so that a partial frame after reset is never written.
REQ-016 VS: on vsync_r=0, SHALL clear the write counter wr_addr to 0, clear overflow, and go to HI.
REQ-017 HI: with href_r=1, SHALL latch din_r as the high byte and go to LO; with href_r=0, SHALL stay in HI.
REQ-018 LO: with href_r=1, SHALL drive pixel_data={hi,din_r}, pixel_address=wr_addr, we=1, increment wr_addr, and go to HI.
REQ-019 LO with href_r=0 (odd byte count): SHALL discard the high byte, write nothing, and go to HI.
REQ-020 Latency: we SHALL be high for the cycle following the 2nd PCLK edge after the edge at which the low byte is on din.
REQ-021 pixel_address and pixel_data SHALL be held stable while we=0.
REQ-022 When wr_addr=76800, further pixels SHALL set overflow and SHALL NOT assert we; wr_addr saturates and never wraps to 0.
REQ-023 vsync_r=1 in HI or LO SHALL pulse frame_done for one cycle and go to VS.
REQ-024 frame_ok SHALL be 1 iff wr_addr=76800 and overflow=0 when frame_done is pulsed.
REQ-025 If vsync_r rises in the same cycle that would complete a pixel in LO, that pixel SHALL be dropped; end of frame takes priority.
REQ-026 href_r=1 while in VS or WAIT_VS SHALL be ignored.

Reset
REQ-027 On RST=1 the state SHALL be WAIT_VS, with wr_addr=0, overflow=0, pixel_address=0, pixel_data=0, we=0, frame_done=0, frame_ok=0, and input registers at 0.
REQ-028 RST asserted mid-frame SHALL abort the frame immediately, with no frame_done; capture resumes only at the next full vsync high-then-low sequence.

Configuration
REQ-029 With CAM_CAPTURE_FRAME_SKIP_EN defined, a frame toggle (0 after reset) SHALL invert on each VS-to-HI transition, and we SHALL be suppressed on frames where the toggle is 0 (every other frame, starting with the first frame captured after reset); frame_done and frame_ok SHALL still be produced for every frame.
REQ-030 With CAM_CAPTURE_FRAME_SKIP_EN not defined, every frame SHALL be written and no toggle logic SHALL exist.

Verification
REQ-031 Full frame: 240 lines of 640 bytes with incrementing pixel values -> 76800 we pulses, addresses 0..76799 in order, data matches, then frame_done=1 and frame_ok=1.
REQ-032 Odd line: a line of 641 bytes -> 320 writes for that line, the trailing byte dropped, and the next line starts at the correct address.
REQ-033 Overflow: 241 lines -> last address 76799, no we beyond that, frame_ok=0.
REQ-034 Short frame: vsync rises after 100 lines -> frame_done with frame_ok=0; the next frame restarts at address 0.
REQ-035 Reset mid-frame: RST pulsed at line 50, then href activity without a new vsync -> we stays 0 until a vsync high-then-low sequence occurs.
REQ-036 Latency: hi byte 0xF8 on din at edge N, lo byte 0x1F at edge N+1 -> we=1 with pixel_data=0xF81F in the cycle after edge N+3; with the macro defined, the first frame has no writes and the second frame has 76800 writes.
